// File: rtl/mem_bus_arbiter_if.sv
// Native picorv32 memory port: valid/ready handshake plus addr/wdata/wstrb/rdata.
// The requester uses the master modport, the arbiter the slave modport.
interface mem_bus_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one 1-cycle-latency RAM and an LED register.
// Fixed 3-cycle transactions; optional bus_err/poison value via MEM_BUS_ARBITER_ERR_EN.
module mem_bus_arbiter #(
  parameter int          RAM_WORDS = 1024,
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] LED_ADDR  = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        led,
  output logic              grant
`ifdef MEM_BUS_ARBITER_ERR_EN
  ,
  output logic              bus_err
`endif
);

  if (RAM_WORDS != (1 << RAM_AW)) begin : g_cfg_err
    $error("mem_bus_arbiter: RAM_WORDS must equal 2**RAM_AW");
  end

`ifdef MEM_BUS_ARBITER_ERR_EN
  localparam logic [31:0] UNMAP_RDATA = 32'hBADC_0DE0;
`else
  localparam logic [31:0] UNMAP_RDATA = 32'h0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [1:0]  ready_q, ready_d;
  logic [7:0]  led_q, led_d;
  logic        sel;
  logic        hit_ram, hit_led;
  logic [31:0] rdata_mux;

`ifdef MEM_BUS_ARBITER_ERR_EN
  logic        err_q, err_d;
`endif

  // Decode always works on the latched address, never the live bus.
  assign hit_ram = ~|req_q.addr[31:RAM_AW+2];
  assign hit_led = (req_q.addr[31:2] == LED_ADDR[31:2]);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ready_d   = ready_q;
    led_d     = led_q;
    sel       = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = req_q.addr[RAM_AW+1:2];
    ram_wdata = req_q.wdata;
`ifdef MEM_BUS_ARBITER_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          // On contention the master that did not win last time goes first.
          sel     = (m0.valid && m1.valid) ? ~last_q : m1.valid;
          grant_d = sel;
          last_d  = sel;
          req_d   = sel ? '{m1.addr, m1.wdata, m1.wstrb}
                        : '{m0.addr, m0.wdata, m0.wstrb};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (hit_ram) begin
          // Gated by resetn so a reset landing mid-ACCESS never commits a write.
          ram_en = resetn;
          ram_we = resetn ? req_q.wstrb : 4'h0;
        end else if (hit_led) begin
          if (req_q.wstrb[0]) led_d = req_q.wdata[7:0];
        end else begin
`ifdef MEM_BUS_ARBITER_ERR_EN
          err_d = 1'b1;
`endif
        end
        ready_d = grant_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end
      RESP: begin
        ready_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ready_q <= 2'b00;
      led_q   <= 8'h0;
`ifdef MEM_BUS_ARBITER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      led_q   <= led_d;
`ifdef MEM_BUS_ARBITER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // RAM data arrives during RESP from the RAM's own output register; the mux
  // is qualified by the registered ready so idle/non-granted rdata stays 0.
  always_comb begin
    rdata_mux = UNMAP_RDATA;
    if (hit_ram)      rdata_mux = ram_rdata;
    else if (hit_led) rdata_mux = {24'h0, led_q};
  end

  assign m0.ready = ready_q[0];
  assign m1.ready = ready_q[1];
  assign m0.rdata = ready_q[0] ? rdata_mux : 32'h0;
  assign m1.rdata = ready_q[1] ? rdata_mux : 32'h0;
  assign led      = led_q;
  assign grant    = grant_q;
`ifdef MEM_BUS_ARBITER_ERR_EN
  assign bus_err  = err_q;
`endif

  // instr is informational and the byte offset is meaningless for word accesses.
  logic unused_ok;
  assign unused_ok = ^{m0.instr, m1.instr, req_q.addr[1:0]};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random + directed bench for mem_bus_arbiter against a transaction-level model
// (memory image, LED value, round-robin owner, 3-phase transaction timeline).
module tb_mem_bus_arbiter;
  localparam int          WORDS = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] LEDA  = 32'h1000_0000;
`ifdef MEM_BUS_ARBITER_ERR_EN
  localparam logic [31:0] UNMAP = 32'hBADC_0DE0;
`else
  localparam logic [31:0] UNMAP = 32'h0;
`endif

  typedef struct {
    bit          act;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } treq_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [7:0]    led;
  logic          grant;
`ifdef MEM_BUS_ARBITER_ERR_EN
  logic          bus_err;
`endif

  mem_bus_arbiter_if m0_if();
  mem_bus_arbiter_if m1_if();

  mem_bus_arbiter #(.RAM_WORDS(WORDS), .RAM_AW(AW), .LED_ADDR(LEDA)) dut (
    .clk(clk), .resetn(resetn), .m0(m0_if), .m1(m1_if),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .led(led), .grant(grant)
`ifdef MEM_BUS_ARBITER_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write, 1-cycle latency.
  logic        ram_clr = 1'b1;
  logic [31:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= 32'h0;
    end else if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [WORDS];
  logic [7:0]  ref_led  = 8'h0;
  bit          ref_err  = 1'b0;
  int          ref_ph   = 0;     // 0 idle, 1 access, 2 response
  bit          ref_own  = 1'b0;
  bit          ref_last = 1'b1;
  treq_t       ref_cur;

  treq_t       mreq [2];
  int          mode = 0;         // 0 one-shot, 1 repeat request, 2 random
  bit          rst_nxt = 1'b0;
  int          cyc = 0;

  int          rdy_q [$];        // owner of each observed ready pulse
  int          rcyc_q [$];       // cycle of each observed ready pulse
  logic [31:0] rd_last [2];
  logic [3:0]  we_val = 4'h0;
  int          we_cyc = 0;

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:2] < 30'(WORDS);
  endfunction
  function automatic bit is_led(input logic [31:0] a);
    return a[31:2] == LEDA[31:2];
  endfunction

  function automatic treq_t rand_req();
    treq_t r;
    int    k;
    k = $urandom_range(7);
    r.act = 1'b1;
    case (k)
      4:       r.addr = 32'h0000_0FFC;                   // last RAM word
      5:       r.addr = LEDA;
      6:       r.addr = 32'h0000_1000;                   // first word past RAM
      7:       r.addr = 32'h2000_0000 | ($urandom_range(255) << 2);
      default: r.addr = $urandom_range(63) << 2;
    endcase
    r.wdata = $urandom;
    r.wstrb = $urandom_range(1) ? 4'h0 : 4'($urandom_range(15));
    return r;
  endfunction

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mreq[m].act = 1'b1; mreq[m].addr = a; mreq[m].wdata = d; mreq[m].wstrb = s;
  endtask

  task automatic drive(input int m);
    logic        v;
    logic [31:0] a;
    v = mreq[m].act;
    a = mreq[m].addr;
    // Out-of-protocol valid drop while owning a transaction.
    if (mode == 2 && ref_ph != 0 && int'(ref_own) == m && $urandom_range(3) == 0) begin
      v = 1'b0;
      a = $urandom;
    end
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = mreq[m].wdata;
      m0_if.wstrb = mreq[m].wstrb; m0_if.instr = 1'($urandom_range(1));
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = mreq[m].wdata;
      m1_if.wstrb = mreq[m].wstrb; m1_if.instr = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit          en_e, rdy_e;
    logic [31:0] rd_e, rd_got;
    bit          rdy_got;
    en_e = resetn && ref_ph == 1 && is_ram(ref_cur.addr);
    chk("ram_en", 32'(ram_en), 32'(en_e));
    chk("ram_we", 32'(ram_we), en_e ? 32'(ref_cur.wstrb) : 32'h0);
    if (en_e) begin
      chk("ram_addr", 32'(ram_addr), 32'(ref_cur.addr[AW+1:2]));
      chk("ram_wdata", ram_wdata, ref_cur.wdata);
    end
    chk("grant", 32'(grant), 32'(ref_own));
    chk("led", 32'(led), 32'(ref_led));
`ifdef MEM_BUS_ARBITER_ERR_EN
    chk("bus_err", 32'(bus_err), 32'(ref_err));
`endif
    if (is_ram(ref_cur.addr))      rd_e = ref_mem[ref_cur.addr[AW+1:2]];
    else if (is_led(ref_cur.addr)) rd_e = {24'h0, ref_led};
    else                           rd_e = UNMAP;
    for (int m = 0; m < 2; m++) begin
      rdy_e   = (ref_ph == 2) && (int'(ref_own) == m);
      rdy_got = (m == 0) ? m0_if.ready : m1_if.ready;
      rd_got  = (m == 0) ? m0_if.rdata : m1_if.rdata;
      chk(m == 0 ? "m0_ready" : "m1_ready", 32'(rdy_got), 32'(rdy_e));
      if (!rdy_e)
        chk(m == 0 ? "m0_rdata_idle" : "m1_rdata_idle", rd_got, 32'h0);
      else if (ref_cur.wstrb == 4'h0)
        chk(m == 0 ? "m0_rdata" : "m1_rdata", rd_got, rd_e);
      if (rdy_got === 1'b1) begin
        rdy_q.push_back(m); rcyc_q.push_back(cyc); rd_last[m] = rd_got;
      end
    end
    if (ram_we !== 4'h0) begin we_val = ram_we; we_cyc = cyc; end
  endtask

  task automatic advance();
    int w;
    if (!resetn) begin
      ref_ph = 0; ref_own = 1'b0; ref_last = 1'b1; ref_led = 8'h0; ref_err = 1'b0;
      return;
    end
    case (ref_ph)
      0: if (mreq[0].act || mreq[1].act) begin
           ref_own  = (mreq[0].act && mreq[1].act) ? ~ref_last : mreq[1].act;
           ref_last = ref_own;
           ref_cur  = mreq[ref_own];
           ref_ph   = 1;
         end
      1: begin
           if (is_ram(ref_cur.addr)) begin
             w = int'(ref_cur.addr[AW+1:2]);
             for (int b = 0; b < 4; b++)
               if (ref_cur.wstrb[b]) ref_mem[w][8*b +: 8] = ref_cur.wdata[8*b +: 8];
           end else if (is_led(ref_cur.addr)) begin
             if (ref_cur.wstrb[0]) ref_led = ref_cur.wdata[7:0];
           end else begin
             ref_err = 1'b1;
           end
           ref_ph = 2;
         end
      default: begin
           if (mode != 1) mreq[ref_own].act = 1'b0;
           ref_ph = 0;
         end
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    resetn = rst_nxt;
    if (mode == 2)
      for (int m = 0; m < 2; m++)
        if (!mreq[m].act && $urandom_range(1) == 1) mreq[m] = rand_req();
    drive(0); drive(1);
    @(negedge clk);
    check_outputs();
    advance();
  endtask

  task automatic wait_done(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!mreq[0].act && !mreq[1].act && ref_ph == 0) begin done = 1'b1; break; end
      step();
    end
    if (!done) done = !mreq[0].act && !mreq[1].act && ref_ph == 0;
    chk("wait_done", 32'(done), 32'h1);
  endtask

  task automatic clrq();
    rdy_q.delete(); rcyc_q.delete();
  endtask

  int t0;

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    mreq[0] = '{1'b0, 32'h0, 32'h0, 4'h0};
    mreq[1] = '{1'b0, 32'h0, 32'h0, 4'h0};
    ref_cur = mreq[0];
    rd_last[0] = 32'h0; rd_last[1] = 32'h0;
    drive(0); drive(1);

    // Reset: outputs idle, RAM image cleared.
    step(); step();
    ram_clr = 1'b0;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);

    // Contention from reset: alternating grants, 3 cycles apart, m0 first.
    mode = 1;
    issue(0, 32'h0, 32'h0, 4'h0);
    issue(1, 32'h4, 32'h0, 4'h0);
    rst_nxt = 1'b1;
    clrq();
    t0 = cyc + 1;
    repeat (12) step();
    mode = 0;
    wait_done(10);
    chk("rr_count", 32'(rdy_q.size() >= 4), 32'h1);
    if (rdy_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk("rr_owner", 32'(rdy_q[k]), 32'(k % 2));
        chk("rr_cycle", 32'(rcyc_q[k] - t0), 32'(2 + 3 * k));
      end

    // m0 full-word write then read back at address 0x10.
    clrq();
    issue(0, 32'h10, 32'hA5A5_0001, 4'hF);
    t0 = cyc + 1;
    wait_done(10);
    chk("wr_we", 32'(we_val), 32'hF);
    chk("wr_we_cyc", 32'(we_cyc - t0), 32'h1);
    chk("wr_rdy", 32'(rdy_q.size()), 32'h1);
    if (rdy_q.size() == 1) chk("wr_lat", 32'(rcyc_q[0] - t0), 32'h2);
    clrq();
    issue(0, 32'h10, 32'h0, 4'h0);
    t0 = cyc + 1;
    wait_done(10);
    chk("rd_0x10", rd_last[0], 32'hA5A5_0001);
    if (rdy_q.size() == 1) chk("rd_lat", 32'(rcyc_q[0] - t0), 32'h2);

    // LED written by m1, read by m0.
    issue(1, LEDA, 32'h0000_005A, 4'h1);
    wait_done(10);
    chk("led_wr", 32'(led), 32'h5A);
    issue(0, LEDA, 32'h0, 4'h0);
    wait_done(10);
    chk("led_rd", rd_last[0], 32'h0000_005A);

    // Single byte-lane write merges into an existing word.
    issue(0, 32'h40, 32'h1122_3344, 4'hF);
    wait_done(10);
    issue(0, 32'h40, 32'h00CC_0000, 4'b0100);
    wait_done(10);
    issue(0, 32'h40, 32'h0, 4'h0);
    wait_done(10);
    chk("byte_merge", rd_last[0], 32'h11CC_3344);

    // Reset landing in ACCESS of a write to 0x20.
    issue(0, 32'h20, 32'h1234_5678, 4'hF);
    step();
    rst_nxt = 1'b0;
    step();
    chk("rst_mid_we", 32'(ram_we), 32'h0);
    mreq[0].act = 1'b0; mreq[1].act = 1'b0;
    rst_nxt = 1'b1;
    step();
    chk("rst_mid_led", 32'(led), 32'h0);
    chk("rst_mid_mem", ram_mem[8], 32'h0);
    clrq();
    issue(0, 32'h4, 32'h0, 4'h0);
    issue(1, 32'h8, 32'h0, 4'h0);
    wait_done(12);
    chk("rst_first_owner", rdy_q.size() > 0 ? 32'(rdy_q[0]) : 32'hFFFF_FFFF, 32'h0);
    issue(0, 32'h20, 32'h0, 4'h0);
    wait_done(10);
    chk("rst_mid_rd", rd_last[0], 32'h0);

    // Unmapped reads: far away and just past the top of RAM.
    issue(0, 32'h2000_0000, 32'h0, 4'h0);
    wait_done(10);
    chk("unmap_rd", rd_last[0], UNMAP);
`ifdef MEM_BUS_ARBITER_ERR_EN
    chk("bus_err_set", 32'(bus_err), 32'h1);
`endif
    issue(1, 32'h1000, 32'h0, 4'h0);
    wait_done(10);
    chk("unmap_edge_rd", rd_last[1], UNMAP);
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_done(10);
`ifdef MEM_BUS_ARBITER_ERR_EN
    chk("bus_err_hold", 32'(bus_err), 32'h1);
`endif
    chk("rd_0x10_again", rd_last[0], 32'hA5A5_0001);

    // Random traffic from both masters.
    mode = 2;
    repeat (3000) step();
    mode = 0;
    wait_done(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
